// File: rtl/nnet_pkg.sv
// Shared constants for the nnet frame arbiter: FSM state encoding and default widths.
package nnet_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int SIZE_W     = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/nnet_rr_arbiter.sv
// Combinational round-robin pick: first requesting port after last_grant, wrapping.
module nnet_rr_arbiter #(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [2:0]           last_grant,
    output logic                 gnt_valid,
    output logic [2:0]           gnt_idx
);
    logic [7:0] req_ext;
    logic [3:0] cand;

    assign req_ext = 8'(req);

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 3'd0;
        cand      = 4'd0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            cand = {1'b0, last_grant} + 4'(i);
            if (cand >= 4'(NUM_PORTS))
                cand = cand - 4'(NUM_PORTS);
            if (req_ext[cand[2:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[2:0];
            end
        end
    end
endmodule

// File: rtl/nnet_frame_arbiter.sv
// Shares one HLS neural-net core among NUM_PORTS streams, one whole frame per grant.
//
// state    | meaning
// ST_IDLE  | no grant; pick next requester round-robin when sizes are non-zero
// ST_FEED  | forward size_in words from granted port to core input
// ST_DRAIN | return size_out core results to granted port, tlast on final word
module nnet_frame_arbiter
    import nnet_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        clear,
    input  logic [SIZE_W-1:0]           size_in,
    input  logic [SIZE_W-1:0]           size_out,
    input  logic [NUM_PORTS*DATA_W-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]        s_tlast,
    input  logic [NUM_PORTS-1:0]        s_tvalid,
    output logic [NUM_PORTS-1:0]        s_tready,
    output logic [NUM_PORTS*DATA_W-1:0] m_tdata,
    output logic [NUM_PORTS-1:0]        m_tlast,
    output logic [NUM_PORTS-1:0]        m_tvalid,
    input  logic [NUM_PORTS-1:0]        m_tready,
    output logic [DATA_W-1:0]           nn_in_tdata,
    output logic                        nn_in_tvalid,
    input  logic                        nn_in_tready,
    input  logic [DATA_W-1:0]           nn_out_tdata,
    input  logic                        nn_out_tvalid,
    output logic                        nn_out_tready,
    output logic                        busy,
    output logic [2:0]                  cur_port,
    output logic [31:0]                 frame_cnt,
    output logic                        err_len
);
    logic [1:0]        state;
    logic [2:0]        port;
    logic [2:0]        last_port;
    logic [SIZE_W-1:0] sz_in, sz_out, in_cnt, out_cnt;
    logic              gnt_valid;
    logic [2:0]        gnt_idx;
    logic              sel_tvalid, sel_tlast, sel_mready;
    logic              in_xfer, out_xfer, in_last, out_last;

    nnet_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .req        (s_tvalid),
        .last_grant (last_port),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign in_last       = (in_cnt == sz_in - 16'd1);
    assign out_last      = (out_cnt == sz_out - 16'd1);
    assign nn_in_tvalid  = (state == ST_FEED) && sel_tvalid;
    assign nn_out_tready = (state == ST_DRAIN) && sel_mready;
    assign in_xfer       = nn_in_tvalid && nn_in_tready;
    assign out_xfer      = nn_out_tvalid && nn_out_tready;
    assign m_tdata       = {NUM_PORTS{nn_out_tdata}};
    assign busy          = (state != ST_IDLE);
    assign cur_port      = port;

    always_comb begin
        nn_in_tdata = '0;
        sel_tvalid  = 1'b0;
        sel_tlast   = 1'b0;
        sel_mready  = 1'b0;
        s_tready    = '0;
        m_tvalid    = '0;
        m_tlast     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port == 3'(p)) begin
                nn_in_tdata = s_tdata[p*DATA_W +: DATA_W];
                sel_tvalid  = s_tvalid[p];
                sel_tlast   = s_tlast[p];
                sel_mready  = m_tready[p];
                s_tready[p] = (state == ST_FEED) && nn_in_tready;
                m_tvalid[p] = (state == ST_DRAIN) && nn_out_tvalid;
                m_tlast[p]  = (state == ST_DRAIN) && out_last;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ST_IDLE;
            port      <= 3'd0;
            last_port <= 3'(NUM_PORTS - 1);
            sz_in     <= '0;
            sz_out    <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            frame_cnt <= '0;
            err_len   <= 1'b0;
        end else if (clear) begin
            state   <= ST_IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            err_len <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (size_in != '0 && size_out != '0 && gnt_valid) begin
                        port    <= gnt_idx;
                        sz_in   <= size_in;
                        sz_out  <= size_out;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        state   <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (in_xfer) begin
                        in_cnt <= in_cnt + 16'd1;
                        // Word count decides the frame; tlast only flags a mismatch.
                        if (in_last) begin
                            state <= ST_DRAIN;
                            if (!sel_tlast)
                                err_len <= 1'b1;
                        end else if (sel_tlast) begin
                            err_len <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_xfer) begin
                        out_cnt <= out_cnt + 16'd1;
                        if (out_last) begin
                            state     <= ST_IDLE;
                            last_port <= port;
                            frame_cnt <= frame_cnt + 32'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nnet_frame_arbiter.sv
// Directed bench for nnet_frame_arbiter with two requesters.
module tb_nnet_frame_arbiter;
    localparam int NP = 2;
    localparam int DW = 32;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             clear = 1'b0;
    logic [15:0]      size_in = 16'd4;
    logic [15:0]      size_out = 16'd2;
    logic [NP*DW-1:0] s_tdata = '0;
    logic [NP-1:0]    s_tlast = '0;
    logic [NP-1:0]    s_tvalid = '0;
    logic [NP-1:0]    s_tready;
    logic [NP*DW-1:0] m_tdata;
    logic [NP-1:0]    m_tlast;
    logic [NP-1:0]    m_tvalid;
    logic [NP-1:0]    m_tready = '1;
    logic [DW-1:0]    nn_in_tdata;
    logic             nn_in_tvalid;
    logic             nn_in_tready = 1'b1;
    logic [DW-1:0]    nn_out_tdata = '0;
    logic             nn_out_tvalid = 1'b0;
    logic             nn_out_tready;
    logic             busy;
    logic [2:0]       cur_port;
    logic [31:0]      frame_cnt;
    logic             err_len;

    int n_total = 0;
    int n_bad   = 0;
    int salt    = 0;

    always #5 ap_clk = ~ap_clk;

    nnet_frame_arbiter #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .clear         (clear),
        .size_in       (size_in),
        .size_out      (size_out),
        .s_tdata       (s_tdata),
        .s_tlast       (s_tlast),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tlast       (m_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .nn_in_tdata   (nn_in_tdata),
        .nn_in_tvalid  (nn_in_tvalid),
        .nn_in_tready  (nn_in_tready),
        .nn_out_tdata  (nn_out_tdata),
        .nn_out_tvalid (nn_out_tvalid),
        .nn_out_tready (nn_out_tready),
        .busy          (busy),
        .cur_port      (cur_port),
        .frame_cnt     (frame_cnt),
        .err_len       (err_len)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] in_word(input int s, input int p, input int k);
        return 32'hA000_0000 | 32'(s << 12) | 32'(p << 8) | 32'(k);
    endfunction

    function automatic logic [31:0] out_word(input int s, input int j);
        return 32'hB000_0000 | 32'(s << 8) | 32'(j);
    endfunction

    task automatic apply_reset();
        ap_rst_n      = 1'b0;
        clear         = 1'b0;
        s_tvalid      = 2'b11;
        nn_out_tvalid = 1'b1;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_nn_in_tvalid", 32'(nn_in_tvalid), 0);
        chk("rst_nn_out_tready", 32'(nn_out_tready), 0);
        chk("rst_cur_port", 32'(cur_port), 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_len", 32'(err_len), 0);
        s_tvalid      = 2'b00;
        nn_out_tvalid = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
    endtask

    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic do_frame(input int port, input int nin, input int nout, input int tl_at,
                            input int stall_at, input int stall_len, input logic [1:0] mask,
                            input int exp_frames);
        salt++;
        s_tvalid      = mask;
        s_tlast       = '0;
        nn_out_tvalid = 1'b0;
        m_tready      = '1;
        for (int p = 0; p < NP; p++) s_tdata[p*DW +: DW] = in_word(salt, p, 0);
        @(negedge ap_clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_s_tready", 32'(s_tready), 0);
        chk("frame_cnt", frame_cnt, 32'(exp_frames));
        @(posedge ap_clk); #1;
        for (int k = 0; k < nin; k++) begin
            for (int p = 0; p < NP; p++) s_tdata[p*DW +: DW] = in_word(salt, p, k);
            s_tlast = (k == tl_at) ? 2'(1 << port) : 2'b00;
            @(negedge ap_clk);
            chk("grant", 32'(cur_port), 32'(port));
            chk("in_valid", 32'(nn_in_tvalid), 1);
            chk("in_data", nn_in_tdata, in_word(salt, port, k));
            chk("s_tready", 32'(s_tready), 32'(1 << port));
            @(posedge ap_clk); #1;
        end
        s_tlast       = '0;
        nn_out_tvalid = 1'b1;
        for (int j = 0; j < nout; j++) begin
            nn_out_tdata = out_word(salt, j);
            if (j == stall_at) begin
                repeat (stall_len) begin
                    m_tready = 2'(~(1 << port));
                    @(negedge ap_clk);
                    chk("stall_out_ready", 32'(nn_out_tready), 0);
                    chk("stall_m_valid", 32'(m_tvalid), 32'(1 << port));
                    @(posedge ap_clk); #1;
                end
                m_tready = '1;
            end
            @(negedge ap_clk);
            chk("m_valid", 32'(m_tvalid), 32'(1 << port));
            chk("m_data", m_tdata[port*DW +: DW], out_word(salt, j));
            chk("m_last", 32'(m_tlast), (j == nout - 1) ? 32'(1 << port) : 0);
            chk("out_ready", 32'(nn_out_tready), 1);
            @(posedge ap_clk); #1;
        end
        nn_out_tvalid = 1'b0;
        s_tvalid      = '0;
    endtask

    initial begin
        apply_reset();

        // Single frame from port 0
        do_frame(0, 4, 2, 3, -1, 0, 2'b01, 0);
        @(negedge ap_clk);
        chk("f1_frame_cnt", frame_cnt, 1);
        chk("f1_err_len", 32'(err_len), 0);
        @(posedge ap_clk); #1;

        // Both ports requesting back to back: strict alternation from port 0
        apply_reset();
        for (int f = 0; f < 6; f++) do_frame(f % 2, 4, 2, 3, -1, 0, 2'b11, f);

        // Result backpressure for 5 cycles mid-drain
        do_frame(0, 4, 2, 3, 1, 5, 2'b01, 6);

        // tlast on the third word of a four-word frame
        do_frame(1, 4, 2, 2, -1, 0, 2'b10, 7);
        @(negedge ap_clk);
        chk("err_len_set", 32'(err_len), 1);
        chk("err_frame_cnt", frame_cnt, 8);
        @(posedge ap_clk); #1;

        // Abort mid-FEED with clear
        s_tvalid = 2'b01;
        s_tlast  = '0;
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        chk("pre_clear_busy", 32'(busy), 1);
        @(posedge ap_clk); #1;
        clear = 1'b1;
        @(posedge ap_clk); #1;
        clear    = 1'b0;
        s_tvalid = '0;
        @(negedge ap_clk);
        chk("clear_busy", 32'(busy), 0);
        chk("clear_err_len", 32'(err_len), 0);
        chk("clear_s_tready", 32'(s_tready), 0);
        chk("clear_frame_cnt", frame_cnt, 8);
        @(posedge ap_clk); #1;
        // last grant was port 1 and survives the abort, so port 0 wins
        do_frame(0, 4, 2, 3, -1, 0, 2'b11, 8);

        // Zero sizes grant nothing
        size_out = 16'd0;
        s_tvalid = 2'b11;
        repeat (3) begin
            @(negedge ap_clk);
            chk("zero_out_busy", 32'(busy), 0);
            chk("zero_out_s_tready", 32'(s_tready), 0);
            @(posedge ap_clk); #1;
        end
        size_out = 16'd2;
        size_in  = 16'd0;
        repeat (2) begin
            @(negedge ap_clk);
            chk("zero_in_busy", 32'(busy), 0);
            @(posedge ap_clk); #1;
        end
        s_tvalid = '0;
        size_in  = 16'd4;
        @(negedge ap_clk);
        chk("zero_frame_cnt", frame_cnt, 9);
        @(posedge ap_clk); #1;

        // Async reset with in_cnt at 2 on port 1
        s_tvalid = 2'b10;
        @(posedge ap_clk); #1;
        repeat (2) @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        chk("pre_rst_in_valid", 32'(nn_in_tvalid), 1);
        chk("pre_rst_port", 32'(cur_port), 1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_s_tready", 32'(s_tready), 0);
        chk("arst_in_valid", 32'(nn_in_tvalid), 0);
        chk("arst_cur_port", 32'(cur_port), 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        s_tvalid = '0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        do_frame(0, 4, 2, 3, -1, 0, 2'b11, 0);
        @(negedge ap_clk);
        chk("final_frame_cnt", frame_cnt, 1);
        chk("final_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/nnet_frame_arbiter.md
# nnet_frame_arbiter

Frame-level scheduler that shares one HLS neural-net core (32-bit AXI-Stream in/out) between NUM_PORTS requesting streams inside an RFNoC compute engine. It grants the core to one requester per frame using round-robin, feeds exactly size_in words, then routes exactly size_out result words back to the granted requester with tlast marking the final word. It sits between the per-port nnet_vector_wrapper outputs and the single ex_modrec-style HLS instance.

## Interface
- NUM_PORTS, 2, number of requesters (2..8)
- DATA_W, 32, stream data width
- ap_clk  in  1  core clock (ce_clk domain)
- ap_rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: return to IDLE, drop current frame
- size_in  in  16  input words per frame (from HLS const_size_in)
- size_out  in  16  output words per frame (from HLS const_size_out)
- s_tdata  in  NUM_PORTS*DATA_W  requester input data, port p at [p*DATA_W +: DATA_W]
- s_tlast / s_tvalid  in  NUM_PORTS  requester input framing / valid
- s_tready  out  NUM_PORTS  requester input ready
- m_tdata / m_tlast / m_tvalid  out  NUM_PORTS*DATA_W / NUM_PORTS / NUM_PORTS  result streams to requesters
- m_tready  in  NUM_PORTS  result ready
- nn_in_tdata / nn_in_tvalid  out  DATA_W / 1  to core input
- nn_in_tready  in  1
- nn_out_tdata / nn_out_tvalid  in  DATA_W / 1  from core output
- nn_out_tready  out  1
- busy  out  1  state != IDLE
- cur_port  out  3  granted port
- frame_cnt  out  32  completed frames, wraps
- err_len  out  1  sticky: s_tlast position disagreed with size_in; cleared by clear

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE: if size_in==0 or size_out==0, grant nothing. Else if any s_tvalid, grant first valid port searching from last_port+1 (mod NUM_PORTS); latch port, size_in, size_out; in_cnt=out_cnt=0; go FEED.
- FEED: nn_in_* = s_*[port], s_tready[port]=nn_in_tready; all others 0. Each transfer increments in_cnt. On transfer with in_cnt==size_in-1 -> DRAIN. s_tlast high at any other count, or low on that final word, sets err_len; data still forwarded (count rules, tlast ignored).
- DRAIN: m_*[port] = nn_out_*, nn_out_tready=m_tready[port]; m_tlast[port]=(out_cnt==size_out-1). Each transfer increments out_cnt; final transfer -> IDLE, last_port=port, frame_cnt+=1.
- Non-granted ports: s_tready=0, m_tvalid=0. nn_out_tready=0 outside DRAIN (core output is held, never dropped).
- size_in/size_out changes mid-frame have no effect until next grant.
- clear: state IDLE, counters 0, err_len 0, last_port kept; frame_cnt kept.

## Timing
- Reset: state IDLE, last_port=NUM_PORTS-1 (port 0 wins first), cur_port=0, all s_tready/m_tvalid/m_tlast/nn_in_tvalid/nn_out_tready 0, busy 0, frame_cnt 0, err_len 0.
- Grant registered: one idle cycle between s_tvalid seen in IDLE and first FEED transfer; one cycle IDLE between DRAIN end and next grant.
- Data path combinational muxes, zero latency; no register in valid/ready path; full throughput within a frame.
- Simultaneous requests: round-robin strictly fair; a port cannot win twice while another is valid.
- Async reset mid-frame: immediate return to reset values; partial frame lost.

## Structure
- Shared package nnet_pkg: state encoding localparams (IDLE/FEED/DRAIN), DATA_W default, SIZE_W=16.
- One sub-module natural: nnet_rr_arbiter (NUM_PORTS request vector + last grant -> one-hot/index grant, combinational).

## Test plan
- NUM_PORTS=2, size_in=4, size_out=2, port0 sends 4 words -> nn_in gets 4 words, port0 gets 2 words, tlast on 2nd, frame_cnt=1.
- Both ports valid continuously, 6 frames -> grants 0,1,0,1,0,1; each m stream receives only its own results.
- m_tready[port] low 5 cycles during DRAIN -> nn_out_tready low same cycles, no word lost or duplicated.
- size_in=4, port sends tlast on word 3 -> err_len=1, 4 words still forwarded; clear -> err_len=0, busy=0.
- size_out=0 with s_tvalid high -> stays IDLE, all s_tready 0, frame_cnt unchanged.
- ap_rst_n asserted mid-FEED (in_cnt=2) -> outputs to reset values same cycle; after release port0 granted first.
